// File: rtl/vu_vxu_banked8_conv_wb_queue.sv
// Writeback queue behind the fixed-latency conversion pipe: a valid/tag delay line
// tracks issued ops, results land in a FIFO, and the head is offered to the register file.
module vu_vxu_banked8_conv_wb_queue #(
  parameter int STAGES = 1,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 65,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_val,
  output logic              issue_rdy,
  input  logic [ADDR_W-1:0] issue_vd,
  input  logic [DATA_W-1:0] conv_out,
  input  logic [EXC_W-1:0]  conv_exc,
  output logic              wb_val,
  input  logic              wb_rdy,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [EXC_W-1:0]  wb_exc,
  input  logic              exc_clr,
  output logic [EXC_W-1:0]  exc_flags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DEPTH + STAGES + 1) + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and both ready outputs come from flops only.
  logic              fire;
  logic              push;
  logic              pop;

  logic [STAGES-1:0] line_vld;
  logic [ADDR_W-1:0] line_tag [STAGES];

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [EXC_W-1:0]  mem_exc  [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [SW-1:0]     inflight;
  logic [SW-1:0]     credit_used;

  assign fire = issue_val & issue_rdy;
  assign push = line_vld[STAGES-1];
  assign pop  = wb_val & wb_rdy;

  // Credits cover both ops still in the conversion pipe and results already buffered,
  // so a result emerging from the pipe always finds a free FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + SW'(line_vld[i]);
    end
  end

  assign credit_used = inflight + SW'(count);
  assign issue_rdy   = credit_used < SW'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      line_vld <= '0;
    end else begin
      line_vld[0] <= fire;
      for (int i = 1; i < STAGES; i++) begin
        line_vld[i] <= line_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    line_tag[0] <= issue_vd;
    for (int i = 1; i < STAGES; i++) begin
      line_tag[i] <= line_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= line_tag[STAGES-1];
      mem_data[wr_ptr] <= conv_out;
      mem_exc[wr_ptr]  <= conv_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign wb_val  = (count != '0);
  assign wb_addr = mem_addr[rd_ptr];
  assign wb_data = mem_data[rd_ptr];
  assign wb_exc  = mem_exc[rd_ptr];

  // A clear in the same cycle as a commit keeps the committing result's flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_flags <= '0;
    end else if (pop) begin
      exc_flags <= (exc_clr ? '0 : exc_flags) | wb_exc;
    end else if (exc_clr) begin
      exc_flags <= '0;
    end
  end

endmodule

// File: tb/tb_vu_vxu_banked8_conv_wb_queue.sv
// Bench for the conversion writeback queue: instance 0 uses a 1-stage pipe, instance 1 a
// 3-stage pipe; a behavioural conversion pipe feeds both and a queue model checks every cycle.
module tb_vu_vxu_banked8_conv_wb_queue;

  localparam int DEPTH = 4;
  localparam int EW    = 110;

  logic        clk;
  logic        reset;
  logic        issue_val [2];
  logic        issue_rdy [2];
  logic [7:0]  issue_vd  [2];
  logic [64:0] conv_out  [2];
  logic [4:0]  conv_exc  [2];
  logic        wb_val    [2];
  logic        wb_rdy    [2];
  logic [7:0]  wb_addr   [2];
  logic [64:0] wb_data   [2];
  logic [4:0]  wb_exc    [2];
  logic        exc_clr   [2];
  logic [4:0]  exc_flags [2];

  logic [64:0] cin_d [2];
  logic [4:0]  cin_e [2];
  logic [64:0] p0_d;
  logic [4:0]  p0_e;
  logic [64:0] p1_d [3];
  logic [4:0]  p1_e [3];

  // expected entry: {ready cycle[31:0], vd[7:0], data[64:0], exc[4:0]}
  logic [EW-1:0] exp_q [2][$];
  logic [4:0]    exp_flags [2];
  int            cyc = 0;
  int            test_cnt = 0;
  int            fail_cnt = 0;
  bit            mon_en = 0;

  vu_vxu_banked8_conv_wb_queue #(.STAGES(1), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .issue_val(issue_val[0]), .issue_rdy(issue_rdy[0]),
    .issue_vd(issue_vd[0]), .conv_out(conv_out[0]), .conv_exc(conv_exc[0]),
    .wb_val(wb_val[0]), .wb_rdy(wb_rdy[0]), .wb_addr(wb_addr[0]), .wb_data(wb_data[0]),
    .wb_exc(wb_exc[0]), .exc_clr(exc_clr[0]), .exc_flags(exc_flags[0])
  );

  vu_vxu_banked8_conv_wb_queue #(.STAGES(3), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .issue_val(issue_val[1]), .issue_rdy(issue_rdy[1]),
    .issue_vd(issue_vd[1]), .conv_out(conv_out[1]), .conv_exc(conv_exc[1]),
    .wb_val(wb_val[1]), .wb_rdy(wb_rdy[1]), .wb_addr(wb_addr[1]), .wb_data(wb_data[1]),
    .wb_exc(wb_exc[1]), .exc_clr(exc_clr[1]), .exc_flags(exc_flags[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // conversion pipe model: free-running, never reset
  always @(posedge clk) begin
    p0_d    <= cin_d[0];
    p0_e    <= cin_e[0];
    p1_d[0] <= cin_d[1];
    p1_e[0] <= cin_e[1];
    p1_d[1] <= p1_d[0];
    p1_e[1] <= p1_e[0];
    p1_d[2] <= p1_d[1];
    p1_e[2] <= p1_e[1];
  end
  assign conv_out[0] = p0_d;
  assign conv_exc[0] = p0_e;
  assign conv_out[1] = p1_d[2];
  assign conv_exc[1] = p1_e[2];

  // scoreboard: inputs are stable at the falling edge and describe the coming rising edge
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          head_ok;
    logic          model_rdy;
    int            stg;
    for (int k = 0; k < 2; k++) begin
      stg = (k == 0) ? 1 : 3;
      if (mon_en) begin
        model_rdy = exp_q[k].size() < DEPTH;
        head_ok   = (exp_q[k].size() != 0) && (int'(exp_q[k][0][109:78]) <= cyc);
        test_cnt++;
        if (issue_rdy[k] !== model_rdy) begin
          fail_cnt++;
          $display("FAIL issue_rdy[%0d] cyc %0d: got %b exp %b", k, cyc, issue_rdy[k], model_rdy);
        end
        test_cnt++;
        if (wb_val[k] !== head_ok) begin
          fail_cnt++;
          $display("FAIL wb_val[%0d] cyc %0d: got %b exp %b", k, cyc, wb_val[k], head_ok);
        end
        test_cnt++;
        if (exc_flags[k] !== exp_flags[k]) begin
          fail_cnt++;
          $display("FAIL exc_flags[%0d] cyc %0d: got %b exp %b", k, cyc, exc_flags[k], exp_flags[k]);
        end
        if (head_ok && wb_rdy[k]) begin
          e = exp_q[k].pop_front();
          test_cnt++;
          if (wb_addr[k] !== e[77:70] || wb_data[k] !== e[69:5] || wb_exc[k] !== e[4:0]) begin
            fail_cnt++;
            $display("FAIL pop[%0d] cyc %0d: got %h/%h/%h exp %h/%h/%h", k, cyc,
                     wb_addr[k], wb_data[k], wb_exc[k], e[77:70], e[69:5], e[4:0]);
          end
          exp_flags[k] = (exc_clr[k] ? 5'b0 : exp_flags[k]) | e[4:0];
        end else if (exc_clr[k]) begin
          exp_flags[k] = 5'b0;
        end
        if (issue_val[k] && model_rdy) begin
          exp_q[k].push_back({32'(cyc + stg + 1), issue_vd[k], cin_d[k], cin_e[k]});
        end
      end
      if (reset) begin
        exp_q[k].delete();
        exp_flags[k] = 5'b0;
      end
    end
    if (mon_en && dut1.push) begin
      test_cnt++;
      if (int'(dut1.count) >= DEPTH) begin
        fail_cnt++;
        $display("FAIL overflow: push with count %0d", dut1.count);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input int k);
    cin_d[k] = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
    cin_e[k] = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue_val[k] = 1'b0; issue_vd[k] = '0; wb_rdy[k] = 1'b0; exc_clr[k] = 1'b0;
      cin_d[k] = '0; cin_e[k] = '0; exp_flags[k] = '0;
    end
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      test_cnt++;
      if (issue_rdy[k] !== 1'b1 || wb_val[k] !== 1'b0 || exc_flags[k] !== 5'b0) begin
        fail_cnt++;
        $display("FAIL reset[%0d]: rdy %b val %b flags %b exp 1 0 0", k, issue_rdy[k], wb_val[k], exc_flags[k]);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    step();
    issue_val[0] = 1'b1; issue_vd[0] = 8'h05; wb_rdy[0] = 1'b1;
    cin_d[0] = 65'h1_0000_0000_3F80_0000; cin_e[0] = 5'b0;
    step();
    issue_val[0] = 1'b0;
    test_cnt++;
    if (wb_val[0] !== 1'b0) begin
      fail_cnt++; $display("FAIL single c1: wb_val %b exp 0", wb_val[0]);
    end
    step();
    test_cnt++;
    if (wb_val[0] !== 1'b1 || wb_addr[0] !== 8'h05 || wb_data[0] !== 65'h1_0000_0000_3F80_0000) begin
      fail_cnt++;
      $display("FAIL single c2: val %b addr %h data %h exp 1 05 100000000_3f800000", wb_val[0], wb_addr[0], wb_data[0]);
    end
    step();
    test_cnt++;
    if (wb_val[0] !== 1'b0) begin
      fail_cnt++; $display("FAIL single c3: wb_val %b exp 0", wb_val[0]);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    wb_rdy[0] = 1'b0;
    issue_val[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      issue_vd[0] = 8'(n);
      rand_op(0);
      if (issue_rdy[0]) n++;
      step();
    end
    issue_val[0] = 1'b0;
    test_cnt++;
    if (n != DEPTH || issue_rdy[0] !== 1'b0) begin
      fail_cnt++; $display("FAIL fill: fires %0d rdy %b exp 4 0", n, issue_rdy[0]);
    end
    wb_rdy[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      test_cnt++;
      if (wb_val[0] !== 1'b1 || wb_addr[0] !== 8'(i) || issue_rdy[0] !== (i != 0)) begin
        fail_cnt++;
        $display("FAIL drain %0d: val %b addr %h rdy %b exp 1 %h %b", i, wb_val[0], wb_addr[0], issue_rdy[0], 8'(i), i != 0);
      end
      step();
    end
    test_cnt++;
    if (wb_val[0] !== 1'b0) begin
      fail_cnt++; $display("FAIL drain end: wb_val %b exp 0", wb_val[0]);
    end
  endtask

  task automatic test_back_to_back();
    issue_val[0] = 1'b1; wb_rdy[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue_vd[0] = 8'(i + 16);
      rand_op(0);
      if (i >= 2) begin
        test_cnt++;
        if (issue_rdy[0] !== 1'b1 || wb_val[0] !== 1'b1 || wb_addr[0] !== 8'(i + 14)) begin
          fail_cnt++;
          $display("FAIL stream %0d: rdy %b val %b addr %h exp 1 1 %h", i, issue_rdy[0], wb_val[0], wb_addr[0], 8'(i + 14));
        end
      end
      step();
    end
    issue_val[0] = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_sticky();
    exc_clr[0] = 1'b1;
    step();
    exc_clr[0] = 1'b0;
    test_cnt++;
    if (exc_flags[0] !== 5'b0) begin
      fail_cnt++; $display("FAIL clr alone: flags %b exp 00000", exc_flags[0]);
    end
    wb_rdy[0] = 1'b0;
    issue_val[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_vd[0] = 8'(i + 64);
      rand_op(0);
      cin_e[0] = (i == 0) ? 5'b00001 : (i == 1) ? 5'b10000 : 5'b00100;
      step();
    end
    issue_val[0] = 1'b0;
    repeat (3) step();
    wb_rdy[0] = 1'b1;
    step();
    test_cnt++;
    if (exc_flags[0] !== 5'b00001) begin
      fail_cnt++; $display("FAIL sticky 1: flags %b exp 00001", exc_flags[0]);
    end
    step();
    test_cnt++;
    if (exc_flags[0] !== 5'b10001) begin
      fail_cnt++; $display("FAIL sticky 2: flags %b exp 10001", exc_flags[0]);
    end
    exc_clr[0] = 1'b1;
    step();
    exc_clr[0] = 1'b0;
    wb_rdy[0] = 1'b0;
    test_cnt++;
    if (exc_flags[0] !== 5'b00100) begin
      fail_cnt++; $display("FAIL sticky clr+pop: flags %b exp 00100", exc_flags[0]);
    end
  endtask

  task automatic test_reset_mid();
    wb_rdy[1] = 1'b0;
    issue_val[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue_vd[1] = 8'(i + 100); rand_op(1); step();
    end
    issue_val[1] = 1'b0;
    repeat (4) step();
    issue_val[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue_vd[1] = 8'(i + 110); rand_op(1); step();
    end
    issue_val[1] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      test_cnt++;
      if (wb_val[k] !== 1'b0 || issue_rdy[k] !== 1'b1 || exc_flags[k] !== 5'b0) begin
        fail_cnt++;
        $display("FAIL mid reset[%0d]: val %b rdy %b flags %b exp 0 1 0", k, wb_val[k], issue_rdy[k], exc_flags[k]);
      end
    end
    wb_rdy[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      test_cnt++;
      if (wb_val[1] !== 1'b0 || wb_val[0] !== 1'b0) begin
        fail_cnt++; $display("FAIL stale after reset %0d: val %b %b exp 0 0", i, wb_val[0], wb_val[1]);
      end
      step();
    end
  endtask

  task automatic test_random();
    int n = 0;
    int c = 0;
    while (n < 1000 && c < 20000) begin
      issue_val[1] = ($urandom_range(0, 3) != 0);
      issue_vd[1]  = 8'($urandom_range(0, 255));
      rand_op(1);
      wb_rdy[1]    = 1'($urandom_range(0, 1));
      exc_clr[1]   = ($urandom_range(0, 15) == 0);
      if (issue_val[1] && issue_rdy[1]) n++;
      step();
      c++;
    end
    issue_val[1] = 1'b0; wb_rdy[1] = 1'b1; exc_clr[1] = 1'b0;
    c = 0;
    while (exp_q[1].size() != 0 && c < 50) begin
      step();
      c++;
    end
    test_cnt++;
    if (n != 1000 || exp_q[1].size() != 0 || exp_q[0].size() != 0) begin
      fail_cnt++;
      $display("FAIL random: fires %0d left %0d/%0d exp 1000 0/0", n, exp_q[1].size(), exp_q[0].size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_sticky();
    test_reset_mid();
    test_random();
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
